channel_llr_pingpong: RTL and testbench

//  Downstream of the channel serial-to-parallel buffer.

---
 rtl/channel_llr_pingpong_if.sv | 26 ++
 rtl/channel_llr_pingpong.sv | 87 ++++++++
 tb/tb_channel_llr_pingpong.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/channel_llr_pingpong_if.sv
// Channel-buffer / decoder side bundle for the LLR ping-pong frame store.
// The master drives words, reads and releases; the slave is the frame store.
interface channel_llr_pingpong_if #(
    parameter int W  = 192,
    parameter int AW = 5
);
    logic [W-1:0]  channel_set_LLR;
    logic          buffer_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          frame_release;
    logic [W-1:0]  rd_data;
    logic          frame_valid;
    logic [7:0]    frame_count;
    logic          overflow;

    modport master (
        output channel_set_LLR, buffer_ready, rd_en, rd_addr, frame_release,
        input  rd_data, frame_valid, frame_count, overflow
    );

    modport slave (
        input  channel_set_LLR, buffer_ready, rd_en, rd_addr, frame_release,
        output rd_data, frame_valid, frame_count, overflow
    );
endinterface

// File: rtl/channel_llr_pingpong.sv
// Two-bank frame store between the channel S/P buffer and the decoder core:
// one bank loads rows while the decoder reads the other completed frame.
module channel_llr_pingpong #(
    parameter int Q  = 6,
    parameter int P  = 32,
    parameter int N  = 1024,
    parameter int AW = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    channel_llr_pingpong_if.slave  bus
);
    localparam int W    = P * Q;
    localparam int ROWS = N / P;

    logic [W-1:0]  mem [2][ROWS];

    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, rd_bank_q;
    logic [AW-1:0] wr_row_q;
    logic          prev_q;
    logic          ovf_q;
    logic [7:0]    cnt_q;
    logic [W-1:0]  rd_data_q;

    logic wr_evt, wr_ok, wr_drop, wr_last, rel;

    // Rising edge of buffer_ready: a held level writes only once.
    assign wr_evt  = bus.buffer_ready && !prev_q;
    assign wr_ok   = wr_evt && !full_q[wr_bank_q];
    assign wr_drop = wr_evt &&  full_q[wr_bank_q];
    assign wr_last = (wr_row_q == AW'(ROWS - 1));
    assign rel     = bus.frame_release && full_q[rd_bank_q];

    // Release and completion can never target the same bank in one cycle:
    // completion needs full=0, release needs full=1.
    always_comb begin
        full_d = full_q;
        if (rel)
            full_d[rd_bank_q] = 1'b0;
        if (wr_ok && wr_last)
            full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            prev_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            prev_q <= bus.buffer_ready;
            full_q <= full_d;
            if (wr_ok) begin
                if (wr_last) begin
                    wr_row_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                    cnt_q     <= cnt_q + 8'd1;
                end else begin
                    wr_row_q  <= wr_row_q + AW'(1);
                end
            end
            if (wr_drop)
                ovf_q <= 1'b1;
            if (rel)
                rd_bank_q <= ~rd_bank_q;
            // Uses the pre-release bank when a read and release coincide.
            if (bus.rd_en)
                rd_data_q <= mem[rd_bank_q][bus.rd_addr];
        end
    end

    // Storage array carries no reset; stale rows are harmless.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wr_bank_q][wr_row_q] <= bus.channel_set_LLR;
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.frame_valid = full_q[rd_bank_q];
    assign bus.frame_count = cnt_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_channel_llr_pingpong.sv
// Directed bench for channel_llr_pingpong: load, read, release, overflow,
// coincident release/write and mid-frame reset.
module tb_channel_llr_pingpong;
    localparam int W = 192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    channel_llr_pingpong_if #(.W(W), .AW(5)) bus ();

    channel_llr_pingpong #(.Q(6), .P(32), .N(1024), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [W-1:0] row(input int k);
        logic [5:0] b;
        b = k[5:0];
        return {32{b}};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [W-1:0] d);
        bus.channel_set_LLR = d;
        bus.buffer_ready    = 1'b1;
        tick();
        bus.buffer_ready    = 1'b0;
        tick();
    endtask

    task automatic rd(input int a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a[4:0];
        tick();
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.channel_set_LLR = '0;
        bus.buffer_ready    = 1'b0;
        bus.rd_en           = 1'b0;
        bus.rd_addr         = '0;
        bus.frame_release   = 1'b0;
        tick();
        tick();
        chk("rst_fv",   bus.frame_valid, 0);
        chk("rst_cnt",  bus.frame_count, 0);
        chk("rst_ovf",  bus.overflow,    0);
        chk("rst_data", bus.rd_data,     0);
        rst = 1'b0;

        // Frame A into bank 0.
        for (int k = 0; k < 32; k++) begin
            pulse(row(k));
            if (k == 30) chk("a_fv_row30", bus.frame_valid, 0);
        end
        chk("a_fv",  bus.frame_valid, 1);
        chk("a_cnt", bus.frame_count, 1);
        rd(5);
        chk("a_rd5", bus.rd_data, row(5));
        rd(31);
        chk("a_rd31", bus.rd_data, row(31));
        bus.rd_addr = 5'd2;
        tick();
        chk("rd_hold", bus.rd_data, row(31));

        // Held level writes exactly one row (bank 1 row 0).
        bus.channel_set_LLR = row(40);
        bus.buffer_ready    = 1'b1;
        repeat (10) tick();
        bus.buffer_ready    = 1'b0;
        tick();
        for (int k = 41; k < 72; k++) begin
            pulse(row(k));
            if (k == 70) chk("lvl_cnt_row30", bus.frame_count, 1);
        end
        chk("lvl_cnt", bus.frame_count, 2);
        chk("lvl_ovf", bus.overflow, 0);

        // Both banks full: next word is dropped.
        pulse(row(99));
        chk("ovf_set", bus.overflow, 1);
        chk("ovf_cnt", bus.frame_count, 2);
        rd(0);
        chk("ovf_b0r0", bus.rd_data, row(0));

        // Read coinciding with release returns the pre-release bank.
        bus.rd_en = 1'b1;
        bus.rd_addr = 5'd0;
        bus.frame_release = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        bus.frame_release = 1'b0;
        chk("relrd_data", bus.rd_data, row(0));
        chk("relrd_fv", bus.frame_valid, 1);
        rd(0);
        chk("b1_rd0", bus.rd_data, row(40));
        rd(31);
        chk("b1_rd31", bus.rd_data, row(71));
        bus.frame_release = 1'b1;
        tick();
        bus.frame_release = 1'b0;
        chk("rel2_fv", bus.frame_valid, 0);

        // Release with nothing valid is ignored.
        bus.frame_release = 1'b1;
        tick();
        bus.frame_release = 1'b0;
        tick();
        chk("idle_rel_fv",  bus.frame_valid, 0);
        chk("idle_rel_cnt", bus.frame_count, 2);
        chk("idle_rel_ovf", bus.overflow, 1);
        rd(5);
        chk("stale_rd5", bus.rd_data, row(5));

        // Frame into bank 0 starts at row 0 after the dropped word.
        for (int k = 0; k < 32; k++) pulse(row(k + 10));
        chk("c_cnt", bus.frame_count, 3);
        chk("c_fv",  bus.frame_valid, 1);
        rd(0);
        chk("c_rd0", bus.rd_data, row(10));

        // Completing write to bank 1 together with release of bank 0.
        for (int k = 0; k < 31; k++) pulse(row(k + 20));
        chk("d_cnt_pre", bus.frame_count, 3);
        bus.channel_set_LLR = row(51);
        bus.buffer_ready    = 1'b1;
        bus.frame_release   = 1'b1;
        tick();
        bus.buffer_ready    = 1'b0;
        bus.frame_release   = 1'b0;
        tick();
        chk("d_fv",  bus.frame_valid, 1);
        chk("d_cnt", bus.frame_count, 4);
        rd(31);
        chk("d_rd31", bus.rd_data, row(51));
        rd(0);
        chk("d_rd0", bus.rd_data, row(20));

        // Write on the cycle a release frees wr_bank is still dropped.
        for (int k = 0; k < 32; k++) pulse(row(k + 30));
        chk("e_cnt", bus.frame_count, 5);
        bus.channel_set_LLR = row(63);
        bus.buffer_ready    = 1'b1;
        bus.frame_release   = 1'b1;
        tick();
        bus.buffer_ready    = 1'b0;
        bus.frame_release   = 1'b0;
        tick();
        chk("e_fv", bus.frame_valid, 1);
        rd(0);
        chk("e_rd0", bus.rd_data, row(30));
        for (int k = 0; k < 32; k++) begin
            pulse(row(k + 1));
            if (k == 30) chk("e_cnt_row30", bus.frame_count, 5);
        end
        chk("e_cnt_done", bus.frame_count, 6);

        // Reset after 17 rows discards the partial frame.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 17; k++) pulse(row(k + 5));
        rst = 1'b1;
        tick();
        chk("mrst_fv",   bus.frame_valid, 0);
        chk("mrst_cnt",  bus.frame_count, 0);
        chk("mrst_ovf",  bus.overflow,    0);
        chk("mrst_data", bus.rd_data,     0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            pulse(row(k + 7));
            if (k == 30) chk("f_fv_row30", bus.frame_valid, 0);
        end
        chk("f_fv",  bus.frame_valid, 1);
        chk("f_cnt", bus.frame_count, 1);
        rd(3);
        chk("f_rd3", bus.rd_data, row(10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
